// File: rtl/me_search_engine_if.sv
// Bus bundle for the block-matching engine: control, memory read ports and results.
// Engine side uses modport slave; the memory/controller side uses master.
interface me_search_engine_if #(
    parameter int PIX_W  = 8,
    parameter int BLK    = 16,
    parameter int RANGE  = 8,
    parameter int DIST_W = 16
);
    localparam int SW   = BLK + 2 * RANGE;
    localparam int MV_W = $clog2(2 * RANGE);
    localparam int RA_W = $clog2(BLK * BLK);
    localparam int SA_W = $clog2(SW * SW);

    logic              start;
    logic              abort;
    logic [RA_W-1:0]   addr_r;
    logic [PIX_W-1:0]  r_data;
    logic [SA_W-1:0]   addr_s;
    logic [PIX_W-1:0]  s_data;
    logic              busy;
    logic              completed;
    logic [DIST_W-1:0] best_dist;
    logic [MV_W-1:0]   motion_x;
    logic [MV_W-1:0]   motion_y;

    modport master (
        output start, abort, r_data, s_data,
        input  addr_r, addr_s, busy, completed, best_dist, motion_x, motion_y
    );

    modport slave (
        input  start, abort, r_data, s_data,
        output addr_r, addr_s, busy, completed, best_dist, motion_x, motion_y
    );
endinterface

// File: rtl/me_search_engine.sv
// Full-search SAD motion estimator over a (BLK+2*RANGE)^2 window.
// Latency: NCAND*(BLK*BLK+2) cycles per search (less with EARLY_TERM).
// Backpressure: none; start while busy is ignored, abort cancels.
module me_search_engine #(
    parameter int PIX_W      = 8,
    parameter int BLK        = 16,
    parameter int RANGE      = 8,
    parameter int DIST_W     = 16,
    parameter bit EARLY_TERM = 1'b0
) (
    input logic              clock,
    input logic              reset_n,
    me_search_engine_if.slave bus
);
    localparam int SW   = BLK + 2 * RANGE;
    localparam int NOFF = 2 * RANGE;
    localparam int MV_W = $clog2(NOFF);
    localparam int RA_W = $clog2(BLK * BLK);
    localparam int SA_W = $clog2(SW * SW);
    localparam int PC_W = $clog2(BLK);
    localparam logic [DIST_W-1:0] DMAX = '1;

    typedef enum logic [2:0] {IDLE, ISSUE, LAST, CMP, DONE} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   px_q, py_q, px_d, py_d;
    logic [MV_W-1:0]   ox_q, oy_q, ox_d, oy_d;
    logic [MV_W-1:0]   mvx_q, mvy_q, mvx_d, mvy_d;
    logic [DIST_W-1:0] acc_q, acc_d, best_q, best_d;
    logic              best_vld_q, best_vld_d;
    logic              rd_vld_q, rd_vld_d;
    logic [RA_W-1:0]   ra_hold_q, ra_cur;
    logic [SA_W-1:0]   sa_hold_q, sa_cur;

    logic [PIX_W-1:0]  diff;
    logic [DIST_W:0]   sum;
    logic [DIST_W-1:0] acc_sat;
    logic              last_pix, last_cand, busy_int, reject, go_next;

    assign ra_cur = RA_W'(int'(py_q) * BLK + int'(px_q));
    assign sa_cur = SA_W'((int'(oy_q) + int'(py_q)) * SW + int'(ox_q) + int'(px_q));

    assign diff    = (bus.r_data >= bus.s_data) ? (bus.r_data - bus.s_data)
                                                : (bus.s_data - bus.r_data);
    assign sum     = {1'b0, acc_q} + (DIST_W+1)'(diff);
    assign acc_sat = sum[DIST_W] ? DMAX : sum[DIST_W-1:0];

    assign last_pix  = (px_q == PC_W'(BLK - 1)) && (py_q == PC_W'(BLK - 1));
    assign last_cand = (ox_q == MV_W'(NOFF - 1)) && (oy_q == MV_W'(NOFF - 1));
    assign busy_int  = (state_q == ISSUE) || (state_q == LAST) || (state_q == CMP);
    // A partial SAD already at or above the best can never win under strict <.
    assign reject    = EARLY_TERM && rd_vld_q && best_vld_q && (acc_sat >= best_q);

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        mvx_d      = mvx_q;
        mvy_d      = mvy_q;
        acc_d      = rd_vld_q ? acc_sat : acc_q;
        best_d     = best_q;
        best_vld_d = best_vld_q;
        rd_vld_d   = 1'b0;
        go_next    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    state_d    = ISSUE;
                    best_vld_d = 1'b0;
                    px_d       = '0;
                    py_d       = '0;
                    ox_d       = '0;
                    oy_d       = '0;
                    acc_d      = '0;
                end
            end
            ISSUE: begin
                rd_vld_d = 1'b1;
                if (last_pix) begin
                    state_d = LAST;
                end else if (px_q == PC_W'(BLK - 1)) begin
                    px_d = '0;
                    py_d = py_q + 1'b1;
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            LAST: state_d = CMP;
            CMP: begin
                if (!best_vld_q || acc_q < best_q) begin
                    best_vld_d = 1'b1;
                    best_d     = acc_q;
                    mvx_d      = ox_q - MV_W'(RANGE);
                    mvy_d      = oy_q - MV_W'(RANGE);
                end
                go_next = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (reject) begin
            rd_vld_d = 1'b0;
            go_next  = 1'b1;
        end

        if (go_next) begin
            acc_d = '0;
            px_d  = '0;
            py_d  = '0;
            if (last_cand) begin
                state_d = DONE;
            end else begin
                state_d = ISSUE;
                if (ox_q == MV_W'(NOFF - 1)) begin
                    ox_d = '0;
                    oy_d = oy_q + 1'b1;
                end else begin
                    ox_d = ox_q + 1'b1;
                end
            end
        end

        // Abort leaves the reported result exactly as it was.
        if (bus.abort && busy_int) begin
            state_d    = IDLE;
            rd_vld_d   = 1'b0;
            acc_d      = '0;
            best_d     = best_q;
            best_vld_d = best_vld_q;
            mvx_d      = mvx_q;
            mvy_d      = mvy_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            mvx_q      <= '0;
            mvy_q      <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            best_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            ra_hold_q  <= '0;
            sa_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            mvx_q      <= mvx_d;
            mvy_q      <= mvy_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_vld_q <= best_vld_d;
            rd_vld_q   <= rd_vld_d;
            if (state_q == ISSUE) begin
                ra_hold_q <= ra_cur;
                sa_hold_q <= sa_cur;
            end
        end
    end

    assign bus.addr_r    = (state_q == ISSUE) ? ra_cur : ra_hold_q;
    assign bus.addr_s    = (state_q == ISSUE) ? sa_cur : sa_hold_q;
    assign bus.busy      = busy_int;
    assign bus.completed = (state_q == DONE);
    assign bus.best_dist = best_q;
    assign bus.motion_x  = mvx_q;
    assign bus.motion_y  = mvy_q;
endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench: BLK=4, RANGE=2 engines (baseline, early-termination, 8-bit SAD).
module tb_me_search_engine;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    me_search_engine_if #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(16)) b0 ();
    me_search_engine_if #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(16)) b1 ();
    me_search_engine_if #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(8))  b2 ();

    me_search_engine #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(16), .EARLY_TERM(1'b0))
        u0 (.clock(clk), .reset_n(reset_n), .bus(b0));
    me_search_engine #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(16), .EARLY_TERM(1'b1))
        u1 (.clock(clk), .reset_n(reset_n), .bus(b1));
    me_search_engine #(.PIX_W(8), .BLK(4), .RANGE(2), .DIST_W(8), .EARLY_TERM(1'b0))
        u2 (.clock(clk), .reset_n(reset_n), .bus(b2));

    logic [7:0] rmem [16];
    logic [7:0] smem [64];

    always @(posedge clk) begin
        b0.r_data <= rmem[b0.addr_r];
        b0.s_data <= smem[b0.addr_s];
        b1.r_data <= rmem[b1.addr_r];
        b1.s_data <= smem[b1.addr_s];
        b2.r_data <= rmem[b2.addr_r];
        b2.s_data <= smem[b2.addr_s];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return b0.completed;
            1:       return b1.completed;
            default: return b2.completed;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    // Pulse start so the next rising edge (cycle 0) samples it.
    task automatic pulse_start(input int sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // Count edges after cycle 0 until completed is seen; bounded.
    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (done_of(sel)) break;
        end
    endtask

    task automatic load_t1();
        for (int i = 0; i < 64; i++) smem[i] = 8'((i * 37 + 11) & 255);
        for (int py = 0; py < 4; py++)
            for (int px = 0; px < 4; px++)
                rmem[py*4+px] = smem[(1 + py) * 8 + 3 + px];
    endtask

    function automatic int sad(input int ox, input int oy);
        int s = 0;
        int d;
        for (int py = 0; py < 4; py++)
            for (int px = 0; px < 4; px++) begin
                d = int'(rmem[py*4+px]) - int'(smem[(oy + py) * 8 + ox + px]);
                s += (d < 0) ? -d : d;
            end
        return s;
    endfunction

    initial begin
        int n;
        int eb, ex, ey, s;
        reset_n  = 1'b0;
        b0.start = 1'b0; b0.abort = 1'b0;
        b1.start = 1'b0; b1.abort = 1'b0;
        b2.start = 1'b0; b2.abort = 1'b0;
        for (int i = 0; i < 64; i++) smem[i] = 8'h00;
        for (int i = 0; i < 16; i++) rmem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", b0.busy, 0);
        chk("rst_completed", b0.completed, 0);
        chk("rst_dist", b0.best_dist, 0);
        chk("rst_addr_s", b0.addr_s, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Exact match at ox=3, oy=1
        load_t1();
        pulse_start(0);
        chk("t1_busy", b0.busy, 1);
        chk("t1_completed_low", b0.completed, 0);
        wait_done(0, n);
        chk("t1_latency", n, 288);
        chk("t1_dist", b0.best_dist, 0);
        chk("t1_mx", b0.motion_x, 2'b01);
        chk("t1_my", b0.motion_y, 2'b11);
        chk("t1_busy_end", b0.busy, 0);
        chk("t1_addr_r_hold", b0.addr_r, 15);
        chk("t1_addr_s_hold", b0.addr_s, 54);

        // Flat image: every candidate ties, first one wins
        for (int i = 0; i < 64; i++) smem[i] = 8'h40;
        for (int i = 0; i < 16; i++) rmem[i] = 8'h40;
        pulse_start(0);
        wait_done(0, n);
        chk("t2_latency", n, 288);
        chk("t2_dist", b0.best_dist, 0);
        chk("t2_mx", b0.motion_x, 2'b10);
        chk("t2_my", b0.motion_y, 2'b10);

        // 8-bit distance saturates (true SAD 4080)
        for (int i = 0; i < 64; i++) smem[i] = 8'hFF;
        for (int i = 0; i < 16; i++) rmem[i] = 8'h00;
        pulse_start(2);
        wait_done(2, n);
        chk("t3_dist_sat", b2.best_dist, 8'hFF);
        chk("t3_mx", b2.motion_x, 2'b10);
        chk("t3_my", b2.motion_y, 2'b10);

        // Early termination: same answer, fewer cycles
        load_t1();
        pulse_start(1);
        wait_done(1, n);
        chk("t4_completed", b1.completed, 1);
        chk("t4_faster", (n < 288), 1);
        chk("t4_dist", b1.best_dist, 0);
        chk("t4_mx", b1.motion_x, 2'b01);
        chk("t4_my", b1.motion_y, 2'b11);

        // Start while busy is ignored, abort at cycle 100
        eb = 0; ex = 0; ey = 0;
        for (int k = 0; k < 5; k++) begin
            s = sad(k % 4, k / 4);
            if (k == 0 || s < eb) begin
                eb = s;
                ex = (k % 4 + 2) & 3;
                ey = (k / 4 + 2) & 3;
            end
        end
        pulse_start(0);
        repeat (49) @(posedge clk);
        @(negedge clk);
        b0.start = 1'b1;
        @(posedge clk);
        #1;
        b0.start = 1'b0;
        chk("t5_busy_after_restart", b0.busy, 1);
        repeat (49) @(posedge clk);
        @(negedge clk);
        b0.abort = 1'b1;
        b0.start = 1'b1;
        @(posedge clk);
        #1;
        b0.abort = 1'b0;
        b0.start = 1'b0;
        chk("t5_abort_busy", b0.busy, 0);
        chk("t5_abort_completed", b0.completed, 0);
        chk("t5_abort_dist", b0.best_dist, eb);
        chk("t5_abort_mx", b0.motion_x, ex);
        chk("t5_abort_my", b0.motion_y, ey);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle", b0.busy, 0);
        pulse_start(0);
        wait_done(0, n);
        chk("t5_latency", n, 288);
        chk("t5_dist", b0.best_dist, 0);
        chk("t5_mx", b0.motion_x, 2'b01);
        chk("t5_my", b0.motion_y, 2'b11);

        // Asynchronous reset mid-search
        pulse_start(0);
        repeat (150) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", b0.busy, 0);
        chk("t6_completed", b0.completed, 0);
        chk("t6_dist", b0.best_dist, 0);
        chk("t6_mx", b0.motion_x, 0);
        chk("t6_my", b0.motion_y, 0);
        chk("t6_addr_r", b0.addr_r, 0);
        chk("t6_addr_s", b0.addr_s, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_busy", b0.busy, 0);
        chk("t6_idle_completed", b0.completed, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
